eight_ten_rx: RTL and testbench

UART receive path for 10-bit (8b/10b-encoded) symbols. It is the receiving end of the team's eight-ten UART transmitter.
- Frame format: 1 start bit (low), 10 symbol bits LSB first, 1 stop bit (high).
- Oversamples the serial line with the system clock and centres each sample mid-bit.
- Delivers the raw 10-bit symbol with a one-cycle valid pulse to the downstream 8b/10b decoder.

---
 rtl/eight_ten_pkg.sv | 7 +
 rtl/eight_ten_rx_sync.sv | 16 +
 rtl/eight_ten_rx.sv | 87 ++++++++
 tb/tb_eight_ten_rx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/eight_ten_pkg.sv
// eight_ten_pkg: shared constants and state encoding for the eight-ten UART pair.
`timescale 1ns/1ps
package eight_ten_pkg;
    localparam int          SYMBOL_W = 10;
    localparam logic [19:0] MIN_BAUD = 20'd15;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/eight_ten_rx_sync.sv
// rx_sync: two-flop synchroniser (resets to line-idle high) with falling-edge pulse.
`timescale 1ns/1ps
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[1:0], rx_i};
    assign rx_s_o = sync_q[1];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/eight_ten_rx.sv
// eight_ten_rx: UART receiver for 10-bit 8b/10b symbols, mid-bit sampled.
`timescale 1ns/1ps
module eight_ten_rx
    import eight_ten_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic [19:0]         baud,
    input  logic                rx,
    output logic [SYMBOL_W-1:0] dout,
    output logic                dout_valid,
    output logic                frame_err,
    output logic                busy
);
    state_e              state_q, state_d;
    logic [19:0]         cyc_q, cyc_d;
    logic [3:0]          bit_q, bit_d;
    logic [SYMBOL_W-1:0] shift_q, shift_d, dout_q, dout_d;
    logic                valid_q, valid_d, err_q, err_d;
    logic                rx_s, fall, half_hit, full_hit;

    rx_sync u_sync (.clk(clk), .rst_n(rst_n), .rx_i(rx), .rx_s_o(rx_s), .fall_o(fall));

    assign half_hit = cyc_q == (baud >> 1) - 20'd1;
    assign full_hit = cyc_q == baud - 20'd1;

    always_comb begin
        state_d = state_q;
        cyc_d   = (state_q == IDLE) ? '0 : cyc_q + 20'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_q != IDLE && !sel) state_d = IDLE;
        else case (state_q)
            IDLE: if (sel && baud >= MIN_BAUD && fall) begin
                state_d = START;
                cyc_d   = '0;
            end
            START: if (half_hit) begin
                state_d = rx_s ? IDLE : DATA;
                cyc_d   = '0;
                bit_d   = '0;
            end
            DATA: if (full_hit) begin
                shift_d[bit_q] = rx_s;
                cyc_d   = '0;
                bit_d   = (bit_q == 4'(SYMBOL_W - 1)) ? '0 : bit_q + 4'd1;
                state_d = (bit_q == 4'(SYMBOL_W - 1)) ? STOP : DATA;
            end
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            STOP: if (full_hit) begin
                state_d = IDLE;
                valid_d = rx_s;
                err_d   = ~rx_s;
                dout_d  = rx_s ? shift_q : dout_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_eight_ten_rx.sv
// tb_eight_ten_rx: directed + random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_eight_ten_rx;
    logic        clk = 1'b0;
    logic        rst_n, sel, rx;
    logic [19:0] baud;
    logic [9:0]  dout;
    logic        dout_valid, frame_err, busy;

    eight_ten_rx dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .baud(baud), .rx(rx),
        .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         valid_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0, valid_cyc = 0;
    logic       busy_at_valid = 1'b0;
    logic [9:0] got[$];
    int         n_assert = 0, n_fail = 0;
    logic [9:0] exp_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            valid_cnt     <= valid_cnt + 1;
            valid_cyc     <= cyc;
            busy_at_valid <= busy;
            got.push_back(dout);
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (dout_valid && frame_err) both_cnt <= both_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] sym, input logic stop_bit, input int nbits);
        int b = int'(baud);
        rx = 1'b0;
        tick(b);
        for (int i = 0; i < nbits; i++) begin
            rx = sym[i];
            tick(b);
        end
        if (nbits == 10) begin
            rx = stop_bit;
            tick(b);
        end
    endtask

    task automatic run_frame(input string tag, input logic [9:0] sym, input logic stop_bit);
        int   v0 = valid_cnt;
        int   e0 = err_cnt;
        logic on = sel && baud >= 20'd15;
        send(sym, stop_bit, 10);
        rx = 1'b1;
        tick(2);
        if (on && stop_bit) exp_dout = sym;
        chk({tag, " valid"}, valid_cnt - v0, (on && stop_bit) ? 1 : 0);
        chk({tag, " err"}, err_cnt - e0, (on && !stop_bit) ? 1 : 0);
        chk({tag, " dout"}, dout, exp_dout);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        int t0, v0, e0, b0;
        rst_n = 1'b0; sel = 1'b0; rx = 1'b1; baud = 20'd16;
        tick(3);
        chk("rst dout", dout, 0);
        chk("rst valid", dout_valid, 0);
        chk("rst err", frame_err, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1; sel = 1'b1;
        tick(5);

        t0 = cyc;
        run_frame("t1", 10'h2A5, 1'b1);
        chk("t1 latency", valid_cyc - t0, 11 * 16 + 8 + 3);
        chk("t1 busy at valid", busy_at_valid, 0);

        run_frame("t2", 10'h17C, 1'b0);
        tick(32);

        v0 = valid_cnt; e0 = err_cnt;
        rx = 1'b0; tick(4); rx = 1'b1; tick(48);
        chk("t3 glitch valid", valid_cnt - v0, 0);
        chk("t3 glitch err", err_cnt - e0, 0);
        chk("t3 glitch busy", busy, 0);
        run_frame("t3", 10'h0F3, 1'b1);

        baud = 20'd14; tick(2);
        b0 = busy_cnt;
        run_frame("t4 b14", 10'h2C3, 1'b1);
        chk("t4 b14 busy never", busy_cnt - b0, 0);
        baud = 20'd15; tick(2);
        run_frame("t4 b15", 10'h2C3, 1'b1);

        baud = 20'd32; tick(2);
        v0 = valid_cnt;
        send(10'h3FF, 1'b1, 10);
        send(10'h000, 1'b1, 10);
        tick(4);
        exp_dout = 10'h000;
        chk("t5 valid count", valid_cnt - v0, 2);
        chk("t5 first", got[got.size() - 2], 10'h3FF);
        chk("t5 second", got[got.size() - 1], 10'h000);
        chk("t5 dout", dout, exp_dout);

        baud = 20'd16; tick(2);
        v0 = valid_cnt;
        send(10'h1E7, 1'b1, 5);
        tick(4);
        chk("t6 busy before reset", busy, 1);
        rst_n = 1'b0; #1;
        chk("t6 rst dout", dout, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst valid", dout_valid, 0);
        chk("t6 rst err", frame_err, 0);
        exp_dout = '0;
        rx = 1'b1; tick(2); rst_n = 1'b1; tick(48);
        chk("t6 rst no valid", valid_cnt - v0, 0);
        run_frame("t6 after rst", 10'h155, 1'b1);

        v0 = valid_cnt; e0 = err_cnt;
        send(10'h0AA, 1'b1, 5);
        tick(4);
        sel = 1'b0;
        tick(1);
        chk("t6 sel busy", busy, 0);
        chk("t6 sel dout kept", dout, exp_dout);
        rx = 1'b1; tick(120);
        chk("t6 sel no valid", valid_cnt - v0, 0);
        chk("t6 sel no err", err_cnt - e0, 0);
        sel = 1'b1; tick(2);
        run_frame("t6 after sel", 10'h155, 1'b1);

        for (int k = 0; k < 8; k++) begin
            baud = 20'($urandom_range(15, 40));
            tick(2);
            run_frame($sformatf("rand%0d", k), 10'($urandom), $urandom_range(0, 3) != 0);
            tick(int'(baud));
        end

        chk("never both", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
